// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the main pipeline
//   writeback (source A) and the multi-cycle unit (source B). It also keeps a
//   busy scoreboard of destinations reserved by in-flight multi-cycle ops and
//   raises decode-stage read hazards.
//
// Ports
//   CLK, RST_N                  clock (rising edge), async active-low reset
//   a_valid/a_reg/a_data        source A write request
//   a_ready                     source A granted this cycle (combinational)
//   b_valid/b_reg/b_data        source B write request
//   b_ready                     source B granted this cycle (combinational)
//   rsv_valid/rsv_reg           reserve a destination for a multi-cycle op
//   read1/read2                 decode-stage source indices
//   hazard1/hazard2             read1/read2 must stall (combinational)
//   RegWrite/wrreg/wrdata       registered register-file write port
//   busy                        scoreboard vector (debug)
module regfile_wb_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_reg,
    input  logic [DW-1:0]   a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_reg,
    input  logic [DW-1:0]   b_data,
    output logic            b_ready,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_reg,
    input  logic [AW-1:0]   read1,
    input  logic [AW-1:0]   read2,
    output logic            hazard1,
    output logic            hazard2,
    output logic            RegWrite,
    output logic [AW-1:0]   wrreg,
    output logic [DW-1:0]   wrdata,
    output logic [NREG-1:0] busy
);

    typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

    src_e            last_q, last_d;
    logic            we_q, we_d;
    logic [AW-1:0]   wrreg_q, wrreg_d;
    logic [DW-1:0]   wrdata_q, wrdata_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic            grant_a, grant_b;

    // Same destination on both sides: B (older result) goes first so that
    // A's younger value is the one left in the register file.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            if (a_reg == b_reg)        grant_b = 1'b1;
            else if (last_q == SRC_B)  grant_a = 1'b1;
            else                       grant_b = 1'b1;
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Output stage and round-robin pointer
    always_comb begin
        last_d   = last_q;
        we_d     = 1'b0;
        wrreg_d  = wrreg_q;
        wrdata_d = wrdata_q;
        if (grant_a) begin
            last_d   = SRC_A;
            we_d     = (a_reg != '0);
            wrreg_d  = a_reg;
            wrdata_d = a_data;
        end else if (grant_b) begin
            last_d   = SRC_B;
            we_d     = (b_reg != '0);
            wrreg_d  = b_reg;
            wrdata_d = b_data;
        end
    end

    // Scoreboard: a new reservation wins over a same-cycle release, and
    // entry 0 never becomes busy.
    always_comb begin
        busy_d    = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_d[i] = (rsv_valid && (rsv_reg == AW'(i))) ||
                        (busy_q[i] && !(grant_b && (b_reg == AW'(i))));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_q   <= SRC_B;
            we_q     <= 1'b0;
            wrreg_q  <= '0;
            wrdata_q <= '0;
            busy_q   <= '0;
        end else begin
            last_q   <= last_d;
            we_q     <= we_d;
            wrreg_q  <= wrreg_d;
            wrdata_q <= wrdata_d;
            busy_q   <= busy_d;
        end
    end

    assign RegWrite = we_q;
    assign wrreg    = wrreg_q;
    assign wrdata   = wrdata_q;
    assign busy     = busy_q;

    // The write currently presented commits only at the end of this cycle,
    // so a matching read must still stall.
    assign hazard1 = (read1 != '0) && (busy_q[read1] || (we_q && wrreg_q == read1));
    assign hazard2 = (read2 != '0) && (busy_q[read2] || (we_q && wrreg_q == read2));

endmodule
